iiitb_pipo_arb: RTL and testbench
=================================

Name: iiitb_pipo_arb

Overview:
- Round-robin write arbiter that shares one WIDTH-bit parallel-in/parallel-out register among NREQ requesters.
- Grants one requester at a time, steers that requester's data onto the register's parallel input, and drives the register's load enable.
- Bounds each grant to MAX_HOLD loads so no requester can starve the others.
- Sits between the requesting blocks and the shared PIPO register. The register captures pi on the rising clk edge when load=1.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, data width of the shared PIPO register
- MAX_HOLD, 4, maximum loads per grant before forced release (>=1)

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  asynchronous, active-low reset (clear=0 resets all state immediately)
- req  input  NREQ  per-requester write request, level-sensitive
- req_data  input  NREQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot registered grant; all zero when idle
- owner  output  clog2(NREQ)  index of current grant holder; valid when busy=1
- busy  output  1  1 while state is OWN
- pi  output  WIDTH  data to the PIPO register's parallel input
- load  output  1  PIPO load enable

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE, gnt=0, owner=0, busy=0, ptr=0, cnt=0.
  - load=0, pi=0.
  - Takes effect immediately mid-grant. The in-flight load is not performed if clear falls before the edge.
- State IDLE:
  - load=0, pi=0.
  - If any req bit is set, select the first set bit scanning ptr, ptr+1, ... modulo NREQ.
  - On the next edge: gnt=onehot(sel), owner=sel, cnt=0, state=OWN.
  - If no req, stay in IDLE.
- State OWN:
  - load = req[owner], combinational.
  - pi = req_data[owner] when load=1, else 0.
  - On each edge with load=1: cnt increments.
  - If load=1 and cnt==MAX_HOLD-1: release (forced).
  - If req[owner]=0: release immediately. No load occurs that cycle.
  - Release means that on the edge: state=IDLE, gnt=0, ptr=(owner+1) mod NREQ, cnt=0.
- Latency and bubble:
  - Request to first load: 1 cycle. Req sampled in IDLE at edge k; load asserted during the cycle after edge k.
  - Exactly one IDLE bubble cycle between consecutive grants.
- Fairness: after a release, the released requester has the lowest priority. With all NREQ requesting continuously, grant order is 0,1,...,NREQ-1,0,...
- Simultaneous events:
  - A new req from a non-owner during OWN is ignored until IDLE.
  - The owner dropping req on the same cycle the forced release would fire behaves as a normal drop release: no load, ptr=owner+1.
- Wrap-around: ptr wraps from NREQ-1 to 0. cnt never exceeds MAX_HOLD-1.
- Widths:
  - cnt is clog2(MAX_HOLD+1) bits.
  - req_data slicing is fixed per requester, with no sign or width conversion.
- Invariants:
  - gnt is one-hot or zero.
  - load=1 implies busy=1 and gnt[owner]=1.
  - pi=0 whenever load=0.

Test Plan:
- Reset: hold clear=0 with req=4'b1111 for 3 cycles -> gnt=0, load=0, pi=0, busy=0 throughout. Release clear -> first grant goes to requester 0.
- Single requester: req[2]=1 with data 4'b1001 for 2 load cycles, then drop.
  - Expect gnt=4'b0100, owner=2.
  - Expect load=1 and pi=4'b1001 for exactly 2 cycles.
  - Register po=4'b1001, then busy=0 on the cycle after the drop.
- Forced release (MAX_HOLD=4): req[1] held continuously with data 4'b1010.
  - Expect exactly 4 load cycles, then 1 IDLE bubble, then a re-grant to requester 1 (sole requester).
  - Expect ptr=2 after the release.
- Round-robin contention: req=4'b1111 constant, data 1011/1110/1111/0000.
  - Grant order 0,1,2,3,0.
  - Each grant gives 4 loads with the matching pi.
  - One bubble between grants.
  - gnt is always one-hot or zero.
- Mid-grant reset: during requester 3's second load, pulse clear=0 asynchronously between edges.
  - gnt, load and pi go to 0 immediately.
  - po keeps its last loaded value.
  - After release, arbitration restarts with ptr=0.
- Drop-versus-forced-release tie: owner 0 deasserts req on the cycle where cnt==MAX_HOLD-1.
  - No load that cycle; state=IDLE; the next grant goes to the lowest set requester at index >=1.

Source files
------------

// File: rtl/iiitb_pipo_arb.sv
// rtl/iiitb_pipo_arb.sv - round-robin write arbiter for one shared PIPO register
module iiitb_pipo_arb #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4,
    localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(MAX_HOLD + 1)
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic [WIDTH-1:0]      pi,
    output logic                  load
);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_owner_nxt;
    logic [OW-1:0]   r_ptr;
    logic [OW-1:0]   w_ptr_nxt;
    logic [OW-1:0]   w_sel;
    logic [OW-1:0]   w_owner_inc;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_own_req;
    logic            w_load;

    // Scan downward so the requester closest to ptr is the last (winning) write.
    always_comb begin
        w_sel = r_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(r_ptr) + i) % NREQ]) begin
                w_sel = OW'((int'(r_ptr) + i) % NREQ);
            end
        end
    end

    assign w_own_req   = req[r_owner];
    assign w_load      = (r_state == S_OWN) && w_own_req;
    assign w_owner_inc = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_OWN;
                    w_gnt_nxt   = NREQ'(1) << w_sel;
                    w_owner_nxt = w_sel;
                    w_cnt_nxt   = '0;
                end
            end
            S_OWN: begin
                // A drop wins over the hold limit: both release, but only a drop skips the load.
                if (!w_own_req || (r_cnt == CW'(MAX_HOLD - 1))) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_owner_inc;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = (r_state == S_OWN);
    assign load  = w_load;
    assign pi    = w_load ? req_data[int'(r_owner)*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_iiitb_pipo_arb.sv
// tb/tb_iiitb_pipo_arb.sv - directed self-checking bench for iiitb_pipo_arb
module tb_iiitb_pipo_arb;

    logic        clk = 1'b0;
    logic        clear;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  pi;
    logic        load;

    logic [3:0]  po = 4'b0000;
    int          load_cnt = 0;
    int          lc0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  rr_data [4];

    iiitb_pipo_arb #(.NREQ(4), .WIDTH(4), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .clear    (clear),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .pi       (pi),
        .load     (load)
    );

    always #5 clk = ~clk;

    // Shared PIPO register; it is not cleared by the arbiter's reset.
    always @(posedge clk) begin
        if (load) begin
            po <= pi;
            load_cnt <= load_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clear) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("load_implies_own", 32'(!load || (busy && gnt[owner])), 32'd1);
            check("pi_zero_no_load", 32'(load || (pi == 4'b0000)), 32'd1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        clear = 1'b0;
        req   = 4'b0000;
        tick();
        clear = 1'b1;
        #1;
    endtask

    initial begin
        rr_data = '{4'b1011, 4'b1110, 4'b1111, 4'b0000};
        clear    = 1'b0;
        req      = 4'b1111;
        req_data = 16'h0FEB;

        // Held in reset with everyone requesting
        repeat (3) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_load", 32'(load), 32'h0);
            check("rst_pi", 32'(pi), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
        end
        clear = 1'b1;
        tick();
        check("rst_first_gnt", 32'(gnt), 32'h1);
        check("rst_first_pi", 32'(pi), 32'hB);

        // Single requester, two loads then drop
        do_reset();
        req      = 4'b0100;
        req_data = 16'h09EB;
        #1;
        check("single_idle_busy", 32'(busy), 32'h0);
        tick();
        lc0 = load_cnt;
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_owner", 32'(owner), 32'h2);
        check("single_load1", 32'(load), 32'h1);
        check("single_pi1", 32'(pi), 32'h9);
        tick();
        check("single_load2", 32'(load), 32'h1);
        check("single_pi2", 32'(pi), 32'h9);
        tick();
        req = 4'b0000;
        #1;
        check("single_drop_load", 32'(load), 32'h0);
        check("single_drop_pi", 32'(pi), 32'h0);
        tick();
        check("single_rel_busy", 32'(busy), 32'h0);
        check("single_rel_gnt", 32'(gnt), 32'h0);
        check("single_loads", 32'(load_cnt - lc0), 32'd2);
        check("single_po", 32'(po), 32'h9);

        // Forced release for a lone continuous requester
        do_reset();
        req      = 4'b0010;
        req_data = 16'h00A0;
        tick();
        lc0 = load_cnt;
        check("force_gnt", 32'(gnt), 32'h2);
        check("force_owner", 32'(owner), 32'h1);
        for (int k = 0; k < 4; k++) begin
            check("force_load", 32'(load), 32'h1);
            check("force_pi", 32'(pi), 32'hA);
            tick();
        end
        check("force_bubble_busy", 32'(busy), 32'h0);
        check("force_bubble_load", 32'(load), 32'h0);
        check("force_loads", 32'(load_cnt - lc0), 32'd4);
        tick();
        check("force_regnt", 32'(gnt), 32'h2);
        req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            check("force_nonowner_ignored", 32'(owner), 32'h1);
            tick();
        end
        check("force_bubble2_busy", 32'(busy), 32'h0);
        tick();
        check("force_ptr2_gnt", 32'(gnt), 32'h8);
        check("force_ptr2_owner", 32'(owner), 32'h3);

        // Round-robin contention
        do_reset();
        req      = 4'b1111;
        req_data = 16'h0FEB;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
            check("rr_owner", 32'(owner), 32'(g % 4));
            for (int k = 0; k < 4; k++) begin
                check("rr_load", 32'(load), 32'h1);
                check("rr_pi", 32'(pi), 32'(rr_data[g % 4]));
                if (k < 3) tick();
            end
            tick();
            check("rr_bubble_busy", 32'(busy), 32'h0);
            check("rr_bubble_gnt", 32'(gnt), 32'h0);
        end

        // Mid-grant asynchronous reset; ptr is 1 here
        req      = 4'b1000;
        req_data = 16'h5FEB;
        tick();
        check("mid_gnt", 32'(gnt), 32'h8);
        check("mid_pi1", 32'(pi), 32'h5);
        tick();
        req_data = 16'h6FEB;
        #1;
        check("mid_pi2", 32'(pi), 32'h6);
        clear = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_load", 32'(load), 32'h0);
        check("mid_rst_pi", 32'(pi), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        req   = 4'b1011;
        clear = 1'b1;
        #1;
        tick();
        check("mid_po_kept", 32'(po), 32'h5);
        check("mid_restart_gnt", 32'(gnt), 32'h1);
        check("mid_restart_owner", 32'(owner), 32'h0);

        // Owner drops on the cycle the hold limit would fire
        lc0 = load_cnt;
        tick();
        tick();
        tick();
        req = 4'b1010;
        #1;
        check("tie_load", 32'(load), 32'h0);
        check("tie_pi", 32'(pi), 32'h0);
        tick();
        check("tie_busy", 32'(busy), 32'h0);
        check("tie_loads", 32'(load_cnt - lc0), 32'd3);
        tick();
        check("tie_next_gnt", 32'(gnt), 32'h2);
        check("tie_next_owner", 32'(owner), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
